// File: rtl/snake_body_engine.sv
// snake_body_engine: stores up to MAX_LEN snake segments, advances the snake one
// cell per accepted step (with optional growth and edge wrap), detects wall and
// self collisions, and answers registered per-pixel head/body hit queries.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en, step, dir, grow   game-process controls (step is a 1-cycle request)
//   scan_x, scan_y        current VGA pixel position
//   busy, done            step in progress / 1-cycle step-complete pulse
//   over, win             sticky end-of-game flags
//   length, head_x/y      current length and head cell
//   pix_head, pix_body    scan pixel hits head / body cell (1-cycle latency)
module snake_body_engine #(
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned INIT_LEN   = 4,
   parameter int unsigned COORD_W    = 11,
   parameter int unsigned CELL_SHIFT = 4,
   parameter int unsigned GRID_W     = 50,
   parameter int unsigned GRID_H     = 37,
   parameter int unsigned WRAP       = 0,
   parameter int unsigned LEN_W      = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               step,
   input  logic [1:0]         dir,
   input  logic               grow,
   input  logic [COORD_W-1:0] scan_x,
   input  logic [COORD_W-1:0] scan_y,
   output logic               busy,
   output logic               done,
   output logic               over,
   output logic               win,
   output logic [LEN_W-1:0]   length,
   output logic [COORD_W-1:0] head_x,
   output logic [COORD_W-1:0] head_y,
   output logic               pix_head,
   output logic               pix_body
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   typedef enum logic [1:0] {IDLE, MOVE, CHECK, DONE} state_e;

   state_e             state_q, state_d;
   logic [1:0]         cur_dir_q, cur_dir_d;
   logic [LEN_W-1:0]   length_q, length_d;
   logic [LEN_W-1:0]   k_q, k_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               over_q, over_d, win_q, win_d;
   logic               grow_pend_q, grow_pend_d;
   logic               pix_head_q, pix_head_d, pix_body_q, pix_body_d;
   logic [COORD_W-1:0] seg_x_q [MAX_LEN];
   logic [COORD_W-1:0] seg_y_q [MAX_LEN];
   logic [COORD_W-1:0] seg_x_d [MAX_LEN];
   logic [COORD_W-1:0] seg_y_d [MAX_LEN];

   logic [COORD_W-1:0] nx, ny, cell_x, cell_y;
   logic               wall, reverse;
   logic [IDX_W-1:0]   k_idx;
   logic [MAX_LEN-1:0] hit;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_dir_q   <= DIR_RIGHT;
         length_q    <= LEN_W'(INIT_LEN);
         k_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         over_q      <= 1'b0;
         win_q       <= 1'b0;
         grow_pend_q <= 1'b0;
         pix_head_q  <= 1'b0;
         pix_body_q  <= 1'b0;
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg_x_q[i] <= COORD_W'(int'(GRID_W / 2) - i);
            seg_y_q[i] <= COORD_W'(GRID_H / 2);
         end
      end else begin
         state_q     <= state_d;
         cur_dir_q   <= cur_dir_d;
         length_q    <= length_d;
         k_q         <= k_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         over_q      <= over_d;
         win_q       <= win_d;
         grow_pend_q <= grow_pend_d;
         pix_head_q  <= pix_head_d;
         pix_body_q  <= pix_body_d;
         seg_x_q     <= seg_x_d;
         seg_y_q     <= seg_y_d;
      end
   end

   // Candidate new head; wall flags an exit, and the wrapped value is precomputed
   always_comb begin
      nx   = seg_x_q[0];
      ny   = seg_y_q[0];
      wall = 1'b0;
      case (cur_dir_q)
         DIR_UP: begin
            if (seg_y_q[0] == '0) begin
               wall = 1'b1;
               ny   = COORD_W'(GRID_H - 1);
            end else ny = seg_y_q[0] - COORD_W'(1);
         end
         DIR_DOWN: begin
            if (seg_y_q[0] == COORD_W'(GRID_H - 1)) begin
               wall = 1'b1;
               ny   = '0;
            end else ny = seg_y_q[0] + COORD_W'(1);
         end
         DIR_LEFT: begin
            if (seg_x_q[0] == '0) begin
               wall = 1'b1;
               nx   = COORD_W'(GRID_W - 1);
            end else nx = seg_x_q[0] - COORD_W'(1);
         end
         default: begin
            if (seg_x_q[0] == COORD_W'(GRID_W - 1)) begin
               wall = 1'b1;
               nx   = '0;
            end else nx = seg_x_q[0] + COORD_W'(1);
         end
      endcase
   end

   // Step FSM: next state and datapath updates
   always_comb begin
      state_d     = state_q;
      cur_dir_d   = cur_dir_q;
      length_d    = length_q;
      k_d         = k_q;
      over_d      = over_q;
      win_d       = win_q;
      done_d      = 1'b0;
      grow_pend_d = grow_pend_q | grow;
      seg_x_d     = seg_x_q;
      seg_y_d     = seg_y_q;
      k_idx       = k_q[IDX_W-1:0];
      // Opposite directions differ only in bit 0
      reverse     = (dir[1] == cur_dir_q[1]) && (dir[0] != cur_dir_q[0]);

      case (state_q)
         IDLE: begin
            if (step && en && !over_q && !win_q) begin
               state_d = MOVE;
               if (!reverse) cur_dir_d = dir;
            end
         end
         MOVE: begin
            if (wall && (WRAP == 0)) begin
               over_d  = 1'b1;
               state_d = DONE;
            end else begin
               // Shift the whole store so a grow keeps the old tail one slot further
               for (int i = 1; i < int'(MAX_LEN); i++) begin
                  seg_x_d[i] = seg_x_q[i-1];
                  seg_y_d[i] = seg_y_q[i-1];
               end
               seg_x_d[0] = nx;
               seg_y_d[0] = ny;
               if (grow_pend_q && (length_q < LEN_W'(MAX_LEN))) begin
                  length_d    = length_q + LEN_W'(1);
                  grow_pend_d = grow;
               end
               k_d     = LEN_W'(1);
               state_d = CHECK;
            end
         end
         CHECK: begin
            if ((seg_x_q[k_idx] == seg_x_q[0]) && (seg_y_q[k_idx] == seg_y_q[0])) begin
               over_d  = 1'b1;
               state_d = DONE;
            end else if (k_q == length_q - LEN_W'(1)) begin
               state_d = DONE;
            end else begin
               k_d = k_q + LEN_W'(1);
            end
         end
         default: begin
            done_d = 1'b1;
            if ((length_q == LEN_W'(MAX_LEN)) && !over_q) win_d = 1'b1;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Pixel query against every live segment in parallel
   always_comb begin
      cell_x = scan_x >> CELL_SHIFT;
      cell_y = scan_y >> CELL_SHIFT;
      hit    = '0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         hit[i] = (LEN_W'(i) < length_q) && (seg_x_q[i] == cell_x) && (seg_y_q[i] == cell_y);
      end
      pix_head_d = hit[0];
      pix_body_d = (|hit[MAX_LEN-1:1]) && !hit[0];
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign over     = over_q;
   assign win      = win_q;
   assign length   = length_q;
   assign head_x   = seg_x_q[0];
   assign head_y   = seg_y_q[0];
   assign pix_head = pix_head_q;
   assign pix_body = pix_body_q;

endmodule
